// File: rtl/fft_stage_sequencer_if.sv
// Start, butterfly-command and status bundle between the FFT stage sequencer
// and its bridge/datapath. The master modport is the sequencer side.
interface fft_stage_sequencer_if #(
   parameter int N_LOG2_MAX = 12
);
   logic                    i_START;
   logic [3:0]              i_LOG2N;
   logic                    o_BF_VALID;
   logic                    i_BF_READY;
   logic [N_LOG2_MAX-1:0]   o_BF_TOP;
   logic [N_LOG2_MAX-1:0]   o_BF_BOT;
   logic [N_LOG2_MAX-2:0]   o_TW_INDEX;
   logic                    o_BF_SWAP;
   logic                    i_BF_DONE;
   logic [3:0]              o_STAGE;
   logic                    o_BUSY;
   logic                    o_CALC_END;
   logic                    o_ERR;

   modport master (
      input  i_START, i_LOG2N, i_BF_READY, i_BF_DONE,
      output o_BF_VALID, o_BF_TOP, o_BF_BOT, o_TW_INDEX, o_BF_SWAP,
             o_STAGE, o_BUSY, o_CALC_END, o_ERR
   );

   modport slave (
      output i_START, i_LOG2N, i_BF_READY, i_BF_DONE,
      input  o_BF_VALID, o_BF_TOP, o_BF_BOT, o_TW_INDEX, o_BF_SWAP,
             o_STAGE, o_BUSY, o_CALC_END, o_ERR
   );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: issues butterfly commands stage by stage under a credit limit.
// Optional bit-reverse swap pass before stage 0 when FFT_SEQ_BITREV_EN is defined.
module fft_stage_sequencer #(
   parameter int N_LOG2_MAX      = 12,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   fft_stage_sequencer_if.master         bus
);
   localparam int         IW      = N_LOG2_MAX;
   localparam int         TW      = N_LOG2_MAX - 1;
   localparam logic [3:0] L_MAX   = 4'(N_LOG2_MAX);
   localparam logic [3:0] CREDITS = 4'(MAX_OUTSTANDING);

`ifdef FFT_SEQ_BITREV_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE, ST_BITREV, ST_BR_DRAIN
   } state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE
   } state_e;
`endif

   state_e          state_q, state_d;
   logic [3:0]      l_q, l_d;
   logic [3:0]      s_q, s_d;
   logic [IW-1:0]   k_q, k_d;
   logic [3:0]      out_q, out_d;
   logic            err_q, err_d;

   logic [3:0]      l_sat;
   logic [IW-1:0]   half, pos, grp, bf_top, bf_bot, n_half_m1;
   logic [3:0]      tw_shift;
   logic            last_stage, has_credit, issue_valid, xfer;
   logic [IW-1:0]   top_o, bot_o;
   logic [TW-1:0]   tw_o;
   logic            swap_o;

   assign l_sat      = (bus.i_LOG2N > L_MAX) ? L_MAX : bus.i_LOG2N;
   assign half       = IW'(1) << s_q;
   assign pos        = k_q & (half - IW'(1));
   assign grp        = k_q >> s_q;
   assign bf_top     = (grp << (s_q + 4'd1)) | pos;
   assign bf_bot     = bf_top + half;
   assign tw_shift   = l_q - 4'd1 - s_q;
   assign n_half_m1  = (IW'(1) << (l_q - 4'd1)) - IW'(1);
   assign last_stage = (s_q == l_q - 4'd1);
   assign has_credit = (out_q != CREDITS);

`ifdef FFT_SEQ_BITREV_EN
   logic [IW-1:0] n_m1, rev_k;
   logic          swap_needed;

   function automatic logic [IW-1:0] rev_bits(input logic [IW-1:0] v);
      logic [IW-1:0] r;
      for (int b = 0; b < IW; b++) r[b] = v[IW-1-b];
      return r;
   endfunction

   // Full-width reversal shifted down leaves the L-bit reversal of k.
   assign n_m1        = (IW'(1) << l_q) - IW'(1);
   assign rev_k       = rev_bits(k_q) >> (L_MAX - l_q);
   assign swap_needed = (k_q < rev_k);
   assign issue_valid = has_credit &&
                        ((state_q == ST_ISSUE) || ((state_q == ST_BITREV) && swap_needed));
`else
   assign issue_valid = has_credit && (state_q == ST_ISSUE);
`endif

   assign xfer = issue_valid && bus.i_BF_READY;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      s_d     = s_q;
      k_d     = k_q;
      err_d   = err_q;
      out_d   = out_q;
      top_o   = '0;
      bot_o   = '0;
      tw_o    = '0;
      swap_o  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.i_START) begin
               l_d   = l_sat;
               s_d   = '0;
               k_d   = '0;
               err_d = 1'b0;
               out_d = '0;
`ifdef FFT_SEQ_BITREV_EN
               state_d = (l_sat == 4'd0) ? ST_DONE : ST_BITREV;
`else
               state_d = (l_sat == 4'd0) ? ST_DONE : ST_ISSUE;
`endif
            end
         end
         ST_ISSUE: begin
            top_o = bf_top;
            bot_o = bf_bot;
            tw_o  = TW'(pos << tw_shift);
            if (xfer) begin
               k_d = k_q + IW'(1);
               if (k_q == n_half_m1) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_q == 4'd0) begin
               if (last_stage) begin
                  state_d = ST_DONE;
               end else begin
                  s_d     = s_q + 4'd1;
                  k_d     = '0;
                  state_d = ST_ISSUE;
               end
            end
         end
`ifdef FFT_SEQ_BITREV_EN
         ST_BITREV: begin
            if (swap_needed) begin
               top_o  = k_q;
               bot_o  = rev_k;
               swap_o = 1'b1;
            end
            // Non-swap indices advance unconditionally; swap indices wait for the transfer.
            if (!swap_needed || xfer) begin
               if (k_q == n_m1) begin
                  k_d     = '0;
                  state_d = ST_BR_DRAIN;
               end else begin
                  k_d = k_q + IW'(1);
               end
            end
         end
         ST_BR_DRAIN: begin
            if (out_q == 4'd0) state_d = ST_ISSUE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      if (xfer && !bus.i_BF_DONE)                       out_d = out_q + 4'd1;
      else if (!xfer && bus.i_BF_DONE && out_q != 4'd0) out_d = out_q - 4'd1;

      if (bus.i_BF_DONE && out_q == 4'd0) err_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         l_q     <= '0;
         s_q     <= '0;
         k_q     <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         s_q     <= s_d;
         k_q     <= k_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign bus.o_BF_VALID = issue_valid;
   assign bus.o_BF_TOP   = top_o;
   assign bus.o_BF_BOT   = bot_o;
   assign bus.o_TW_INDEX = tw_o;
   assign bus.o_BF_SWAP  = swap_o;
   assign bus.o_STAGE    = s_q;
   assign bus.o_CALC_END = (state_q == ST_DONE);
   assign bus.o_ERR      = err_q;
`ifdef FFT_SEQ_BITREV_EN
   assign bus.o_BUSY = (state_q == ST_ISSUE) || (state_q == ST_DRAIN) ||
                       (state_q == ST_BITREV) || (state_q == ST_BR_DRAIN);
`else
   assign bus.o_BUSY = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: directed scenarios plus randomized runs
// compared against a loop-based model of the DIT butterfly schedule.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;
   localparam int NL   = 12;
   localparam int MAXO = 4;

   typedef struct {
      int top;
      int bot;
      int tw;
      int swap;
      int stage;
   } cmd_t;

   logic clk;
   logic rst;

   fft_stage_sequencer_if #(.N_LOG2_MAX(NL)) bus ();

   fft_stage_sequencer #(.N_LOG2_MAX(NL), .MAX_OUTSTANDING(MAXO)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, observed=running required=finished");
      $fatal(1, "watchdog");
   end

   cmd_t exp_q[$];
   int   due_q[$];
   int   n_cmp, n_err;
   int   cyc, inflight, last_due, done_delay, xfers;
   logic obs_valid, obs_busy, obs_cend, obs_err;
   int   obs_top, obs_bot, obs_stage;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Schedule written as nested group/offset loops; twiddle stride = N / span.
   task automatic build_model(input int l);
      int n;
      n = 1 << l;
      exp_q.delete();
`ifdef FFT_SEQ_BITREV_EN
      for (int i = 0; i < n && l > 0; i++) begin
         int r;
         r = 0;
         for (int b = 0; b < l; b++) if (((i >> b) & 1) == 1) r = r | (1 << (l - 1 - b));
         if (i < r) exp_q.push_back('{i, r, 0, 1, 0});
      end
`endif
      for (int s = 0; s < l; s++) begin
         int span, hlf, stride;
         span   = 2 << s;
         hlf    = 1 << s;
         stride = n / span;
         for (int g = 0; g < n; g += span)
            for (int j = 0; j < hlf; j++)
               exp_q.push_back('{g + j, g + j + hlf, j * stride, 0, s});
      end
   endtask

   task automatic step(input bit rdy, input bit done_en, input bit start, input int l2);
      @(negedge clk);
      cyc++;
      obs_valid = bus.o_BF_VALID;
      obs_busy  = bus.o_BUSY;
      obs_cend  = bus.o_CALC_END;
      obs_err   = bus.o_ERR;
      obs_top   = int'(bus.o_BF_TOP);
      obs_bot   = int'(bus.o_BF_BOT);
      obs_stage = int'(bus.o_STAGE);
      if (inflight == MAXO) check("no_credit_valid", obs_valid, 0);
      bus.i_START    = start;
      bus.i_LOG2N    = 4'(l2);
      bus.i_BF_READY = rdy;
      bus.i_BF_DONE  = 1'b0;
      if (done_en && due_q.size() > 0 && due_q[0] <= cyc) begin
         void'(due_q.pop_front());
         bus.i_BF_DONE = 1'b1;
         inflight--;
      end
      if (obs_valid && rdy) begin
         int d;
         xfers++;
         check("cmd_available", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            cmd_t e;
            e = exp_q.pop_front();
            check("bf_top",   bus.o_BF_TOP,         e.top);
            check("bf_bot",   bus.o_BF_BOT,         e.bot);
            check("tw_index", bus.o_TW_INDEX,       e.tw);
            check("bf_swap",  bus.o_BF_SWAP,        e.swap);
            check("stage",    bus.o_STAGE,          e.stage);
         end
         inflight++;
         check("credit_bound", inflight <= MAXO, 1);
         d = cyc + done_delay;
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         due_q.push_back(d);
      end
      @(posedge clk);
   endtask

   task automatic start_fft(input int l, input int dly);
      build_model(l);
      due_q.delete();
      inflight   = 0;
      last_due   = 0;
      xfers      = 0;
      done_delay = dly;
      step(1'b0, 1'b0, 1'b1, l);
   endtask

   task automatic run_to_end(input string tag, input int pct);
      int c;
      c = 0;
      do begin
         step(($urandom_range(99) < pct), 1'b1, 1'b0, 0);
         c++;
      end while (!obs_cend && c < 3000);
      check({tag, "_calc_end"},   obs_cend,     1);
      check({tag, "_all_cmds"},   exp_q.size(), 0);
      check({tag, "_all_dones"},  due_q.size(), 0);
      check({tag, "_busy_low"},   obs_busy,     0);
      check({tag, "_valid_low"},  obs_valid,    0);
      check({tag, "_err_low"},    obs_err,      0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, bus.o_BF_VALID, 0);
      check({tag, "_top"},   bus.o_BF_TOP,   0);
      check({tag, "_bot"},   bus.o_BF_BOT,   0);
      check({tag, "_tw"},    bus.o_TW_INDEX, 0);
      check({tag, "_swap"},  bus.o_BF_SWAP,  0);
      check({tag, "_stage"}, bus.o_STAGE,    0);
      check({tag, "_busy"},  bus.o_BUSY,     0);
      check({tag, "_cend"},  bus.o_CALC_END, 0);
      check({tag, "_err"},   bus.o_ERR,      0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; inflight = 0; last_due = 0; xfers = 0; done_delay = 2;
      obs_cend = 1'b0;
      rst            = 1'b1;
      bus.i_START    = 1'b0;
      bus.i_LOG2N    = 4'd0;
      bus.i_BF_READY = 1'b0;
      bus.i_BF_DONE  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk) rst = 1'b0;

      // L=3, ready held, done two cycles after each transfer
      start_fft(3, 2);
      step(1'b1, 1'b1, 1'b0, 0);
`ifndef FFT_SEQ_BITREV_EN
      check("first_cmd_latency", obs_valid, 1);
`endif
      check("busy_after_start", obs_busy, 1);
      run_to_end("l3", 100);

      // Backpressure on the first command of L=2
      start_fft(2, 2);
`ifdef FFT_SEQ_BITREV_EN
      step(1'b0, 1'b1, 1'b0, 0);
`endif
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 0);
         check("bp_valid", obs_valid, 1);
         check("bp_top",   obs_top,   exp_q[0].top);
         check("bp_bot",   obs_bot,   exp_q[0].bot);
      end
      run_to_end("backpressure", 100);

      // Credit limit with dones withheld
      start_fft(4, 1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0);
      check("credit_xfers", xfers, MAXO);
      check("credit_valid_low", obs_valid, 0);
      step(1'b0, 1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 0);
      check("credit_returns", obs_valid, 1);
      run_to_end("credit", 100);

      // Done pulse while idle sets the sticky error; next start clears it
      @(negedge clk) bus.i_BF_DONE = 1'b1;
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 0);
      check("err_set", obs_err, 1);
      check("err_cend_held", obs_cend, 1);
      start_fft(2, 1);
      step(1'b1, 1'b1, 1'b0, 0);
      check("err_cleared", obs_err, 0);
      run_to_end("err_restart", 100);

      // Start during ISSUE must not disturb k, stage or L
      start_fft(3, 2);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 1'b1, 5);
      run_to_end("start_ignored", 100);

      // Reset in the middle of stage 1
      start_fft(3, 2);
      begin
         int c;
         c = 0;
         do begin
            step(1'b1, 1'b1, 1'b0, 0);
            c++;
         end while (!(obs_stage == 1 && obs_busy) && c < 200);
      end
      check("reach_stage1", obs_stage, 1);
      @(negedge clk);
      bus.i_BF_DONE  = 1'b0;
      bus.i_BF_READY = 1'b0;
      #1 rst = 1'b1;
      #1 check_zero("mid_reset");
      @(negedge clk) rst = 1'b0;
      start_fft(3, 1);
      run_to_end("after_reset", 100);

      // L=0: calc-end one cycle after start, no commands
      start_fft(0, 1);
      step(1'b1, 1'b1, 1'b0, 0);
      check("l0_cend",  obs_cend,  1);
      check("l0_valid", obs_valid, 0);
      check("l0_busy",  obs_busy,  0);
      check("l0_xfers", xfers,     0);

      // Randomized lengths, ready density and done latency
      for (int r = 0; r < 6; r++) begin
         int l, pct;
         l   = $urandom_range(5, 1);
         pct = $urandom_range(100, 40);
         start_fft(l, $urandom_range(4, 1));
         run_to_end("random", pct);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Controller sequencing an in-place radix-2 DIT FFT over the sample RAM after the AXI bridge has loaded it.
- Started by the bridge's data-loaded pulse. Issues butterfly commands (top/bottom RAM index plus twiddle index) to the butterfly datapath over a valid/ready handshake.
- Limits in-flight butterflies with a credit counter and drains between stages to respect data dependencies.
- Raises calc-end, which the bridge waits on before serving AXI reads.

Parameters:
- N_LOG2_MAX, 12, largest supported log2(FFT length); index width.
- MAX_OUTSTANDING, 4, maximum butterflies issued but not yet reported done (1..15).

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_START  in  1  one-cycle start pulse (driven from bridge o_DATA_LOADED)
- i_LOG2N  in  4  log2 of FFT length, sampled on accepted i_START
- o_BF_VALID  out  1  butterfly command valid
- i_BF_READY  in  1  datapath accepts command
- o_BF_TOP  out  N_LOG2_MAX  RAM index of upper operand
- o_BF_BOT  out  N_LOG2_MAX  RAM index of lower operand
- o_TW_INDEX  out  N_LOG2_MAX-1  twiddle ROM index
- o_BF_SWAP  out  1  command is a plain swap (bit-reverse pass), not a butterfly
- i_BF_DONE  in  1  one-cycle pulse per completed command write-back
- o_STAGE  out  4  current stage number
- o_BUSY  out  1  sequence in progress
- o_CALC_END  out  1  transform complete (level)
- o_ERR  out  1  sticky protocol error

Behaviour:
- Reset (async, i_rst=1): state IDLE. All outputs 0. Counters and latched L cleared.
- Latched length L = i_LOG2N on accepted start, saturated to N_LOG2_MAX; N = 1<<L.
- States: IDLE, ISSUE, DRAIN, DONE, plus BITREV when the optional feature is compiled in.
- IDLE: i_START=1 -> clear o_CALC_END, o_ERR, k, stage and outstanding; latch L. Go to ISSUE, or DONE if L=0.
- ISSUE:
  - o_BF_VALID=1 unless outstanding == MAX_OUTSTANDING.
  - Transfer = o_BF_VALID & i_BF_READY. Payload stays stable while valid is held without ready.
  - For stage s and butterfly k (0..N/2-1): half=1<<s, pos=k&(half-1), grp=k>>s.
  - o_BF_TOP = (grp<<(s+1))|pos. o_BF_BOT = o_BF_TOP+half. o_TW_INDEX = pos<<(L-1-s). o_BF_SWAP=0.
  - k increments on transfer. A transfer with k=N/2-1 goes to DRAIN.
- DRAIN:
  - o_BF_VALID=0. Wait for outstanding==0.
  - Then, if s==L-1, go to DONE. Otherwise s++, k=0, back to ISSUE.
- DONE: o_CALC_END=1, o_BUSY=0. Stay in DONE until the next i_START, which is handled as in IDLE.
- o_BUSY=1 in ISSUE, DRAIN and BITREV. o_STAGE=s.
- Outstanding counter:
  - +1 on transfer, -1 on i_BF_DONE; unchanged when both occur in the same cycle.
  - i_BF_DONE with outstanding==0 sets o_ERR and the counter holds at 0.
- Ignored inputs:
  - i_START while busy: ignored, no error.
  - i_BF_DONE in IDLE or DONE: ignored, except the outstanding==0 error rule above still applies.
- Latency: first command valid one cycle after the i_START cycle.
- Throughput: one butterfly per cycle while ready is held and credit is available.
- Minimum total butterflies: L*N/2.
- Reset mid-operation: immediate return to IDLE; in-flight commands are forgotten.

Optional Feature:
- Macro: FFT_SEQ_BITREV_EN.
- When defined, an accepted start enters BITREV before stage 0:
  - Index i scans 0..N-1, one index per cycle when no command is pending.
  - For each i < rev_L(i), issue a command with o_BF_SWAP=1, o_BF_TOP=i, o_BF_BOT=rev_L(i), o_TW_INDEX=0, using the same handshake and credit rules.
  - Other i are skipped in one cycle.
  - After i=N-1, drain to outstanding==0, then enter ISSUE at s=0.
- When undefined: BITREV is absent and o_BF_SWAP is tied to 0. Input is assumed pre-ordered by the bridge.

Test Plan:
- L=3, i_BF_READY=1, i_BF_DONE two cycles after each transfer:
  - 12 butterflies in order: (0,1),(2,3),(4,5),(6,7) tw 0,0,0,0; (0,2),(1,3),(4,6),(5,7) tw 0,2,0,2; (0,4),(1,5),(2,6),(3,7) tw 0,1,2,3.
  - o_CALC_END rises after the last done; o_STAGE steps 0,1,2.
- Backpressure: L=2, i_BF_READY low for 5 cycles on the first command -> o_BF_TOP=0, o_BF_BOT=1 held stable; no k advance.
- Credit limit: MAX_OUTSTANDING=4, L=4, i_BF_DONE withheld -> exactly 4 transfers, then o_BF_VALID=0 until a done pulse.
- Error and restart: i_BF_DONE pulse in IDLE -> o_ERR=1; next i_START clears it. i_START during ISSUE -> no effect on k or stage.
- Reset mid-stage: assert i_rst during stage 1 of L=3 -> all outputs 0 the same cycle. A new i_START restarts at stage 0, k=0.
- FFT_SEQ_BITREV_EN, L=3: swaps (1,4),(3,6) with o_BF_SWAP=1 precede the 12 butterflies. L=0 -> o_CALC_END one cycle after start, no commands.
